// File: rtl/row_pixel_streamer_pkg.sv
// Shared types and helpers for the row pixel streamer: FSM state encoding,
// pixel type and frame-buffer address width.
package row_pixel_streamer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        SHIFT,
        LATCH
    } state_e;

    localparam int PIX_BITS_DEFAULT = 24;
    typedef logic [PIX_BITS_DEFAULT-1:0] pixel_t;

    // Address is {bank, arm, row, col}.
    function automatic int addr_width(input int h, input int w);
        return 2 + $clog2(h) + $clog2(w);
    endfunction

endpackage

// File: rtl/row_pixel_streamer_if.sv
// Frame-buffer read port: the streamer drives address and strobe, the
// buffer returns pixel data one cycle after the strobe.
interface row_pixel_streamer_if
    import row_pixel_streamer_pkg::*;
#(
    parameter int AW       = addr_width(1024, 32),
    parameter int PIX_BITS = PIX_BITS_DEFAULT
);
    logic [AW-1:0]       mem_addr;
    logic                mem_rd;
    logic [PIX_BITS-1:0] mem_rdata;

    modport master (output mem_addr, output mem_rd, input mem_rdata);
    modport slave  (input mem_addr, input mem_rd, output mem_rdata);
endinterface

// File: rtl/row_pixel_streamer_led_shift_out.sv
// MSB-first pixel serializer for the LED driver chain. Each bit is presented
// with sclk low for CLK_DIV cycles, then high for CLK_DIV cycles.
module led_shift_out #(
    parameter int PIX_BITS = 24,
    parameter int CLK_DIV  = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                load,
    input  logic [PIX_BITS-1:0] data,
    output logic                done,
    output logic                sclk,
    output logic                sdata
);
    localparam int BW = $clog2(PIX_BITS);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(PIX_BITS - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(CLK_DIV - 1);

    // Remaining bits after the one currently on sdata.
    logic [PIX_BITS-2:0] sreg;
    logic [BW-1:0]       bit_cnt;
    logic [DW-1:0]       div_cnt;
    logic                active;
    logic                phase_end;

    assign phase_end = active && (div_cnt == LAST_DIV);
    assign done      = phase_end && sclk && (bit_cnt == LAST_BIT);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
            div_cnt <= '0;
            active  <= 1'b0;
            sclk    <= 1'b0;
            sdata   <= 1'b0;
        end else if (load) begin
            sreg    <= data[PIX_BITS-2:0];
            sdata   <= data[PIX_BITS-1];
            sclk    <= 1'b0;
            active  <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            if (!phase_end) begin
                div_cnt <= div_cnt + 1'b1;
            end else begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                end else begin
                    // Falling edge: advance to the next bit or go quiet.
                    sclk <= 1'b0;
                    if (bit_cnt == LAST_BIT) begin
                        active <= 1'b0;
                        sdata  <= 1'b0;
                    end else begin
                        sdata   <= sreg[PIX_BITS-2];
                        sreg    <= {sreg[PIX_BITS-3:0], 1'b0};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/row_pixel_streamer.sv
// Fetches both arms' pixels for each new row pair from the frame buffer and
// streams them into the blade LED driver chain, then latches.
module row_pixel_streamer
    import row_pixel_streamer_pkg::*;
#(
    parameter int IMG_HEIGHT = 1024,
    parameter int IMG_WIDTH  = 32,
    parameter int PIX_BITS   = 24,
    parameter int CLK_DIV    = 1,
    localparam int RW        = $clog2(IMG_HEIGHT)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [RW-1:0]         row,
    input  logic [RW-1:0]         rowEven,
    input  logic                  valid,
    input  logic                  index,
    input  logic                  rowChange,
    row_pixel_streamer_if.master  mem,
    output logic                  led_sclk,
    output logic                  led_sdata,
    output logic                  led_latch,
    output logic                  busy,
    output logic                  overrun
);
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [DW-1:0] LAST_LAT = DW'(CLK_DIV - 1);

    state_e        state, next_state;
    logic          req_bank, pend_bank, pend_valid;
    logic [RW-1:0] req_row, req_row_even, pend_row, pend_row_even;
    logic          arm;
    logic [CW-1:0] col;
    logic [DW-1:0] lat_cnt;
    logic          accept, start_new, start_pend, store_pend;
    logic          shift_done, latch_last, col_last;

    assign accept     = rowChange && valid;
    assign latch_last = (state == LATCH) && (lat_cnt == LAST_LAT);
    assign col_last   = (col == LAST_COL);
    assign store_pend = accept && (state != IDLE) && !start_new;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        next_state = state;
        start_new  = 1'b0;
        start_pend = 1'b0;
        case (state)
            IDLE: if (accept) begin
                next_state = FETCH;
                start_new  = 1'b1;
            end
            FETCH: next_state = LOAD;
            LOAD:  next_state = SHIFT;
            SHIFT: if (shift_done) next_state = (col_last && arm) ? LATCH : FETCH;
            LATCH: if (latch_last) begin
                // A fresh accept in the final latch cycle wins over a stored one.
                if (accept) begin
                    next_state = FETCH;
                    start_new  = 1'b1;
                end else if (pend_valid && valid) begin
                    next_state = FETCH;
                    start_pend = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_bank      <= 1'b0;
            req_row       <= '0;
            req_row_even  <= '0;
            pend_valid    <= 1'b0;
            pend_bank     <= 1'b0;
            pend_row      <= '0;
            pend_row_even <= '0;
            arm           <= 1'b0;
            col           <= '0;
            lat_cnt       <= '0;
            overrun       <= 1'b0;
        end else begin
            overrun <= accept && pend_valid;
            lat_cnt <= (state == LATCH) ? lat_cnt + 1'b1 : '0;

            if (start_new) begin
                req_bank     <= index;
                req_row      <= row;
                req_row_even <= rowEven;
            end else if (start_pend) begin
                req_bank     <= pend_bank;
                req_row      <= pend_row;
                req_row_even <= pend_row_even;
            end

            if (store_pend) begin
                pend_valid    <= 1'b1;
                pend_bank     <= index;
                pend_row      <= row;
                pend_row_even <= rowEven;
            end else if (start_new || start_pend || !valid) begin
                pend_valid <= 1'b0;
            end

            if (start_new || start_pend) begin
                arm <= 1'b0;
                col <= '0;
            end else if (state == SHIFT && shift_done) begin
                col <= col_last ? '0 : col + 1'b1;
                if (col_last) arm <= ~arm;
            end
        end
    end

    assign mem.mem_addr = {req_bank, arm, (arm ? req_row_even : req_row), col};
    assign mem.mem_rd   = (state == FETCH);
    assign led_latch    = (state == LATCH);
    assign busy         = (state != IDLE);

    led_shift_out #(
        .PIX_BITS (PIX_BITS),
        .CLK_DIV  (CLK_DIV)
    ) u_shift (
        .clk   (clk),
        .reset (reset),
        .load  (state == LOAD),
        .data  (mem.mem_rdata),
        .done  (shift_done),
        .sclk  (led_sclk),
        .sdata (led_sdata)
    );

endmodule
